// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
// Holds the 3-bit operation encodings and the shift-op classifier.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  // True for every op that moves data by one bit position and so advances the frame count.
  function automatic logic is_shift(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
           (mode == MODE_ROR) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_frame_counter.sv
// Frame counter for the universal shift register.
// Counts acted shifts modulo WIDTH; emits a registered one-cycle frame_done
// pulse in the cycle after the WIDTH-th shift of a frame.
module shift_frame_counter #(
  parameter int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next count: clear wins, a shift on the last slot wraps and raises the pulse.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count and pulse registers; reset overrides everything, including mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign cnt        = cnt_q;
  assign frame_done = done_q;

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: shifts, rotates, arithmetic shift, load and clear,
// with a frame counter that pulses after every WIDTH shifts.
// Optional feature macro USR_PARITY_EN: registered even-parity output.
// Without it the parity port is tied low and no parity logic exists.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] out,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             frame_done,
  output logic             parity
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] out_q, out_d;
  logic             act;
  logic             cnt_inc;
  logic             cnt_clr;
  logic [CNT_W-1:0] frame_cnt;

  assign act     = clk_en & en & ~rst;
  assign cnt_inc = act & is_shift(mode);
  assign cnt_clr = act & ((mode == MODE_LOAD) || (mode == MODE_CLR));

  // Data mux: select the next register value for the requested op.
  always_comb begin
    out_d = out_q;
    if (act) begin
      case (mode)
        MODE_SHL:  out_d = {out_q[WIDTH-2:0], ser_in_l};
        MODE_SHR:  out_d = {ser_in_r, out_q[WIDTH-1:1]};
        MODE_ROL:  out_d = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        MODE_ROR:  out_d = {out_q[0], out_q[WIDTH-1:1]};
        MODE_ASR:  out_d = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
        MODE_LOAD: out_d = par_in;
        MODE_CLR:  out_d = '0;
        default:   out_d = out_q;
      endcase
    end
  end

  // Data register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  shift_frame_counter #(
    .WIDTH(WIDTH)
  ) u_frame_counter (
    .clk       (clk),
    .rst       (rst),
    .inc       (cnt_inc),
    .clr       (cnt_clr),
    .cnt       (frame_cnt),
    .frame_done(frame_done)
  );

`ifdef USR_PARITY_EN
  logic parity_q;

  // Parity tracks the value being written into out, so it lines up with out.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^out_d;
    end
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

  assign out       = out_q;
  assign ser_out_l = out_q[WIDTH-1];
  assign ser_out_r = out_q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Scoreboard bench for universal_shift_register (WIDTH=4).
// The driver applies stimulus on the falling edge and pushes the expected
// post-edge state from an integer model; the monitor pops and compares after
// every rising edge.
module tb_universal_shift_register;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, clk_en, en, ser_in_l, ser_in_r;
  logic [2:0]   mode;
  logic [W-1:0] par_in;
  logic [W-1:0] out;
  logic         ser_out_l, ser_out_r, frame_done, parity;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .en(en), .mode(mode),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .par_in(par_in),
    .out(out), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
    .frame_done(frame_done), .parity(parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int val;
    bit fd;
    bit par;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // Reference state: register value as an integer and shifts seen in this frame.
  int m_val    = 0;
  int m_shifts = 0;
  int txn_id   = 0;

  task automatic check(input string name, input int id, input int act_v, input int exp_v);
    n_cmp++;
    if (act_v != exp_v) begin
      n_bad++;
      $display("FAIL txn %0d %s: got %0d expected %0d", id, name, act_v, exp_v);
    end
  endtask

  // One clock of stimulus; the model is advanced and the expectation queued.
  task automatic step(input bit r, input bit ce, input bit e, input int md,
                      input bit sl, input bit sr, input int pin);
    exp_t x;
    bit   fd;
    @(negedge clk);
    rst = r; clk_en = ce; en = e; mode = 3'(md);
    ser_in_l = sl; ser_in_r = sr; par_in = W'(pin);
    fd = 1'b0;
    if (r) begin
      m_val = 0; m_shifts = 0;
    end else if (ce && e) begin
      case (md)
        1: m_val = ((m_val << 1) | int'(sl)) & MASK;
        2: m_val = (m_val >> 1) | (int'(sr) << (W - 1));
        3: m_val = ((m_val << 1) | (m_val >> (W - 1))) & MASK;
        4: m_val = (m_val >> 1) | ((m_val & 1) << (W - 1));
        6: m_val = (m_val >> 1) | (m_val & (1 << (W - 1)));
        5: m_val = pin & MASK;
        7: m_val = 0;
        default: ;
      endcase
      if (md inside {1, 2, 3, 4, 6}) begin
        m_shifts++;
        if (m_shifts == W) begin
          fd = 1'b1;
          m_shifts = 0;
        end
      end else if (md == 5 || md == 7) begin
        m_shifts = 0;
      end
    end
    x.id  = txn_id;
    x.val = m_val;
    x.fd  = fd;
`ifdef USR_PARITY_EN
    x.par = ($countones(m_val) % 2) == 1;
`else
    x.par = 1'b0;
`endif
    exp_q.push_back(x);
    $display("txn %0d: rst=%0b ce=%0b en=%0b mode=%0d sl=%0b sr=%0b par_in=%0h -> exp out=%0h fd=%0b",
             txn_id, r, ce, e, md, sl, sr, pin, m_val, fd);
    txn_id++;
  endtask

  // Monitor: the DUT presents a new state after every rising edge.
  initial begin
    exp_t x;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("out",        x.id, int'(out),        x.val);
        check("ser_out_l",  x.id, int'(ser_out_l),  (x.val >> (W - 1)) & 1);
        check("ser_out_r",  x.id, int'(ser_out_r),  x.val & 1);
        check("frame_done", x.id, int'(frame_done), int'(x.fd));
        check("parity",     x.id, int'(parity),     int'(x.par));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clk_en = 1'b0; en = 1'b0; mode = 3'd0;
    ser_in_l = 1'b0; ser_in_r = 1'b0; par_in = '0;

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 5, 0, 0, 4'hF);
    // LOAD 1011 then SHL with 0 three times.
    step(0, 1, 1, 5, 0, 0, 4'b1011);
    repeat (3) step(0, 1, 1, 1, 0, 0, 0);
    // LOAD 1001 then ROR x4, then HOLD to see the pulse clear.
    step(0, 1, 1, 5, 0, 0, 4'b1001);
    repeat (4) step(0, 1, 1, 4, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    // ASR twice on 1000; CLR; SHR with 1 on 0000.
    step(0, 1, 1, 5, 0, 0, 4'b1000);
    repeat (2) step(0, 1, 1, 6, 0, 0, 0);
    step(0, 1, 1, 7, 0, 0, 0);
    step(0, 1, 1, 2, 0, 1, 0);
    // clk_en toggling with SHL of ones.
    step(0, 1, 1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 0, 0);
    // Reset mid-frame (cnt=2), then a full frame must need four more shifts.
    step(0, 1, 1, 5, 0, 0, 4'b0110);
    repeat (2) step(0, 1, 1, 3, 0, 0, 0);
    step(1, 1, 1, 3, 0, 0, 0);
    repeat (4) step(0, 1, 1, 3, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    // 3 shifts, LOAD, 4 shifts; then CLR.
    repeat (3) step(0, 1, 1, 1, 1, 0, 0);
    step(0, 1, 1, 5, 0, 0, 4'b0101);
    repeat (4) step(0, 1, 1, 2, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 1, 1, 7, 0, 0, 0);

    // Randomized traffic, shift-heavy so frames complete often.
    for (int i = 0; i < 400; i++) begin
      int md;
      md = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7))
                                       : int'($urandom_range(1, 4));
      if (md == 5 && $urandom_range(0, 1) == 1) md = 6;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 5) != 0,
           $urandom_range(0, 5) != 0, md,
           1'($urandom), 1'($urandom), int'($urandom_range(0, MASK)));
    end

    @(posedge clk);
    #2;
    done = 1'b1;
    check("queue_drained", -1, exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
